// File: rtl/ir_player_pkg.sv
// Shared types and constants for the IR code player: FSM states, ROM word
// field positions (in half-word units) and the minimum usable carrier period.
package ir_player_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR_WAIT,
        HDR_LOAD,
        PAIR_WAIT,
        PAIR_LOAD,
        MARK,
        SPACE,
        FINISH
    } state_t;

    // Each ROM word holds two half-word fields; index 1 is the upper half.
    localparam int unsigned HDR_PERIOD_FIELD = 0;
    localparam int unsigned HDR_COUNT_FIELD  = 1;
    localparam int unsigned PAIR_OFF_FIELD   = 0;
    localparam int unsigned PAIR_ON_FIELD    = 1;

    localparam int unsigned MIN_PERIOD = 2;

endpackage

// File: rtl/ir_carrier_gen.sv
// Carrier phase counter with duty comparator; phase restarts at 0 while
// restart is high and wraps after period-1.
module ir_carrier_gen #(
    parameter int unsigned PW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          restart,
    input  logic [PW-1:0] period,
    input  logic          duty_sel,
    output logic          carrier
);

    logic [PW-1:0] ph;
    logic [PW-1:0] third;
    logic [PW-1:0] thresh;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ph <= '0;
        end else if (restart || ph == period - PW'(1)) begin
            ph <= '0;
        end else begin
            ph <= ph + PW'(1);
        end
    end

    always_comb begin
        third = period / PW'(3);
        if (third == '0) begin
            third = PW'(1);
        end
        thresh  = duty_sel ? third : (period >> 1);
        carrier = (ph < thresh);
    end

endmodule

// File: rtl/ir_code_player.sv
// Plays one ROM-resident IR code (header + mark/space pairs) onto N_CH
// masked LED channels with a modulated carrier during marks.
module ir_code_player
    import ir_player_pkg::*;
#(
    parameter int unsigned AW   = 8,
    parameter int unsigned DW   = 16,
    parameter int unsigned N_CH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [AW-1:0]   code_addr,
    input  logic [N_CH-1:0] ch_mask,
    input  logic            duty_sel,
    input  logic            abort,
    output logic [AW-1:0]   rom_addr,
    input  logic [DW-1:0]   rom_data,
    output logic            busy,
    output logic            done,
    output logic [N_CH-1:0] ir_out
);

    localparam int unsigned HW = DW / 2;

    state_t          state;
    logic [N_CH-1:0] mask;
    logic            duty;
    logic [HW-1:0]   period;
    logic [HW-1:0]   count;
    logic [HW-1:0]   off_len;
    logic [DW-1:0]   dur;
    logic            carrier;

    logic [HW-1:0]   hdr_period;
    logic [HW-1:0]   hdr_count;
    logic [HW-1:0]   pair_on;
    logic [HW-1:0]   pair_off;
    logic [HW-1:0]   eff_period;
    logic [HW-1:0]   space_len;
    logic [DW-1:0]   mark_cyc;
    logic [DW-1:0]   space_cyc;
    logic            pair_end;

    assign hdr_period = rom_data[HDR_PERIOD_FIELD*HW +: HW];
    assign hdr_count  = rom_data[HDR_COUNT_FIELD*HW +: HW];
    assign pair_on    = rom_data[PAIR_ON_FIELD*HW +: HW];
    assign pair_off   = rom_data[PAIR_OFF_FIELD*HW +: HW];

    assign eff_period = (hdr_period < HW'(MIN_PERIOD)) ? HW'(MIN_PERIOD) : hdr_period;
    assign space_len  = (state == PAIR_LOAD) ? pair_off : off_len;
    assign mark_cyc   = DW'(pair_on) * DW'(period);
    assign space_cyc  = DW'(space_len) * DW'(period);

    // A pair ends without entering SPACE when its off count is zero, so a
    // zero-length space costs no cycles at all.
    assign pair_end = (state == PAIR_LOAD && pair_on == '0 && pair_off == '0) ||
                      (state == MARK && dur == '0 && off_len == '0) ||
                      (state == SPACE && dur == '0);

    ir_carrier_gen #(.PW(HW)) u_carrier (
        .clk      (clk),
        .rst_n    (rst_n),
        .restart  (state != MARK),
        .period   (period),
        .duty_sel (duty),
        .carrier  (carrier)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            rom_addr <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            ir_out   <= '0;
            mask     <= '0;
            duty     <= 1'b0;
            period   <= '0;
            count    <= '0;
            off_len  <= '0;
            dur      <= '0;
        end else begin
            done   <= 1'b0;
            ir_out <= (state == MARK && carrier) ? mask : '0;
            if (abort && state != IDLE) begin
                state  <= IDLE;
                busy   <= 1'b0;
                ir_out <= '0;
            end else if (pair_end) begin
                count <= count - HW'(1);
                if (count == HW'(1)) begin
                    state <= FINISH;
                end else begin
                    rom_addr <= rom_addr + AW'(1);
                    state    <= PAIR_WAIT;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !abort) begin
                            mask     <= ch_mask;
                            duty     <= duty_sel;
                            rom_addr <= code_addr;
                            busy     <= 1'b1;
                            state    <= HDR_WAIT;
                        end
                    end
                    HDR_WAIT:  state <= HDR_LOAD;
                    HDR_LOAD: begin
                        period <= eff_period;
                        count  <= hdr_count;
                        if (hdr_count == '0) begin
                            state <= FINISH;
                        end else begin
                            rom_addr <= rom_addr + AW'(1);
                            state    <= PAIR_WAIT;
                        end
                    end
                    PAIR_WAIT: state <= PAIR_LOAD;
                    PAIR_LOAD: begin
                        off_len <= pair_off;
                        if (pair_on != '0) begin
                            dur   <= mark_cyc - DW'(1);
                            state <= MARK;
                        end else begin
                            dur   <= space_cyc - DW'(1);
                            state <= SPACE;
                        end
                    end
                    MARK: begin
                        if (dur != '0) begin
                            dur <= dur - DW'(1);
                        end else begin
                            dur   <= space_cyc - DW'(1);
                            state <= SPACE;
                        end
                    end
                    SPACE: dur <= dur - DW'(1);
                    FINISH: begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ir_code_player.sv
// Self-checking bench for ir_code_player: directed and random codes checked
// cycle by cycle against a timeline model built from the code's ROM words.
module tb_ir_code_player;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        duty_sel = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  code_addr = '0;
    logic [3:0]  ch_mask = '0;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data;
    logic        busy;
    logic        done;
    logic [3:0]  ir_out;

    logic [15:0] rom [256];
    int          checks = 0;
    int          errors = 0;

    // Per busy cycle: the LED drive the code calls for and the ROM address held.
    logic [3:0]  exp_ir[$];
    logic [7:0]  exp_addr[$];

    ir_code_player #(.AW(8), .DW(16), .N_CH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .code_addr (code_addr),
        .ch_mask   (ch_mask),
        .duty_sel  (duty_sel),
        .abort     (abort),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .busy      (busy),
        .done      (done),
        .ir_out    (ir_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic build_model(input logic [7:0] base, input logic [3:0] m, input logic d);
        logic [7:0]  a;
        logic [15:0] w;
        int p, c, on, off, thr;
        exp_ir.delete();
        exp_addr.delete();
        a = base;
        w = rom[a];
        p = int'(w[7:0]);
        if (p < 2) p = 2;
        c = int'(w[15:8]);
        thr = d ? ((p / 3 < 1) ? 1 : p / 3) : p / 2;
        repeat (2) begin exp_ir.push_back(4'b0); exp_addr.push_back(a); end
        if (c > 0) a = a + 8'd1;
        for (int i = 0; i < c; i++) begin
            w   = rom[a];
            on  = int'(w[15:8]);
            off = int'(w[7:0]);
            repeat (2) begin exp_ir.push_back(4'b0); exp_addr.push_back(a); end
            for (int t = 0; t < on * p; t++) begin
                exp_ir.push_back(((t % p) < thr) ? m : 4'b0);
                exp_addr.push_back(a);
            end
            for (int t = 0; t < off * p; t++) begin
                exp_ir.push_back(4'b0);
                exp_addr.push_back(a);
            end
            if (i < c - 1) a = a + 8'd1;
        end
        exp_ir.push_back(4'b0);
        exp_addr.push_back(a);
    endtask

    // cut: -1 play to the end, -2 interrupt at the last SPACE cycle, else at
    // that cycle index; kind 0 interrupts with abort, kind 1 with reset.
    task automatic run_code(input logic [7:0] base, input logic [3:0] m, input logic d,
                            input bit noise, input int cut, input int kind);
        int n, cj;
        logic [3:0] e_ir;
        build_model(base, m, d);
        n  = exp_ir.size();
        cj = (cut == -2) ? n - 2 : cut;
        code_addr = base;
        ch_mask   = m;
        duty_sel  = d;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int j = 0; j <= n + 1; j++) begin
            if (j > 0) begin @(posedge clk); #1; end
            e_ir = (j >= 1 && j - 1 < n) ? exp_ir[j-1] : 4'b0;
            check($sformatf("busy@%02h.%0d", base, j), 32'(busy), 32'(j < n));
            check($sformatf("done@%02h.%0d", base, j), 32'(done), 32'(j == n));
            check($sformatf("ir@%02h.%0d", base, j), 32'(ir_out), 32'(e_ir));
            check($sformatf("addr@%02h.%0d", base, j), 32'(rom_addr),
                  32'((j < n) ? exp_addr[j] : exp_addr[n-1]));
            if (j == cj) begin
                start = 1'b0;
                if (kind == 0) abort = 1'b1; else rst_n = 1'b0;
                @(posedge clk); #1;
                abort = 1'b0;
                rst_n = 1'b1;
                check($sformatf("cut_ir@%02h", base), 32'(ir_out), 32'(0));
                check($sformatf("cut_busy@%02h", base), 32'(busy), 32'(0));
                check($sformatf("cut_done@%02h", base), 32'(done), 32'(0));
                if (kind == 1) check($sformatf("rst_addr@%02h", base), 32'(rom_addr), 32'(0));
                return;
            end
            if (noise && j < n - 1) begin
                start     = 1'($urandom_range(0, 1));
                code_addr = 8'($urandom);
                ch_mask   = 4'($urandom);
                duty_sel  = 1'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
    endtask

    task automatic make_rand_code(input logic [7:0] base, input int c);
        rom[base] = {8'(c), 8'($urandom_range(0, 7))};
        for (int i = 1; i <= c; i++) begin
            rom[base + 8'(i)] = {8'($urandom_range(0, 3)), 8'($urandom_range(0, 3))};
        end
    endtask

    initial begin
        foreach (rom[i]) rom[i] = '0;

        // Reset dominates start and abort.
        rst_n = 1'b0; start = 1'b1; abort = 1'b1; code_addr = 8'h10; ch_mask = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_ir", 32'(ir_out), 32'(0));
        check("rst_addr", 32'(rom_addr), 32'(0));
        start = 1'b0; abort = 1'b0; rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_busy", 32'(busy), 32'(0));

        rom[8'h10] = 16'h0104; rom[8'h11] = 16'h0201;
        run_code(8'h10, 4'b0001, 1'b0, 1'b0, -1, 0);

        rom[8'h20] = 16'h0106; rom[8'h21] = 16'h0100;
        run_code(8'h20, 4'b1010, 1'b1, 1'b0, -1, 0);

        rom[8'h30] = 16'h0000;
        run_code(8'h30, 4'b1111, 1'b0, 1'b0, -1, 0);
        rom[8'h38] = 16'h0101; rom[8'h39] = 16'h0101;
        run_code(8'h38, 4'b0110, 1'b0, 1'b0, -1, 0);
        rom[8'h3C] = 16'h0100; rom[8'h3D] = 16'h0201;
        run_code(8'h3C, 4'b1001, 1'b1, 1'b0, -1, 0);

        rom[8'h40] = 16'h0303; rom[8'h41] = 16'h0002;
        rom[8'h42] = 16'h0200; rom[8'h43] = 16'h0000;
        run_code(8'h40, 4'b1100, 1'b0, 1'b1, -1, 0);

        rom[8'h50] = 16'h0105; rom[8'h51] = 16'h0302;
        run_code(8'h50, 4'b1111, 1'b0, 1'b0, 5, 0);
        run_code(8'h10, 4'b0001, 1'b0, 1'b0, -1, 0);

        rom[8'h60] = 16'h0104; rom[8'h61] = 16'h0103;
        run_code(8'h60, 4'b0101, 1'b0, 1'b0, -2, 1);
        run_code(8'h20, 4'b1010, 1'b1, 1'b0, -1, 0);

        rom[8'hFF] = 16'h0203; rom[8'h00] = 16'h0101; rom[8'h01] = 16'h0102;
        run_code(8'hFF, 4'b0011, 1'b1, 1'b0, -1, 0);

        // Abort together with start in IDLE keeps the player idle.
        code_addr = 8'h10; start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        check("abort_start_busy0", 32'(busy), 32'(0));
        @(posedge clk); #1;
        check("abort_start_busy1", 32'(busy), 32'(0));

        for (int k = 0; k < 12; k++) begin
            logic [7:0] b;
            b = 8'h80 + 8'(k * 8);
            make_rand_code(b, int'($urandom_range(0, 3)));
            run_code(b, 4'($urandom), 1'($urandom), 1'b1, -1, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
